// File: rtl/psum_accum_buffer_if.sv
// Beat bus from the systolic array and the drained result stream of psum_accum_buffer.
// The master side drives the array beats and out_ready_i; the buffer is the slave.
interface psum_accum_buffer_if #(
  parameter int N_COLS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int NUMBER_SUPPORTED_FILTERS = 32,
  parameter int DEPTH                    = 64
);
  localparam int OUT_W = I_WIDTH + F_WIDTH;
  localparam int NG    = (NUMBER_SUPPORTED_FILTERS + N_COLS_ARRAY - 1) / N_COLS_ARRAY;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW    = (NG > 1) ? $clog2(NG) : 1;

  logic                          in_valid_i;
  logic [N_COLS_ARRAY*OUT_W-1:0] in_data_i;
  logic [AW-1:0]                 in_addr_i;
  logic [GW-1:0]                 in_group_i;
  logic                          in_round_done_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic signed [OUT_W-1:0]       out_data_o;
  logic                          out_last_o;

  modport master (
    output in_valid_i, in_data_i, in_addr_i, in_group_i, in_round_done_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_addr_i, in_group_i, in_round_done_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/psum_accum_buffer.sv
// Per-pixel, per-filter partial-sum accumulator across channel rounds, with
// ReLU / shift / saturation post-processing and a valid/ready drain stream.
module psum_accum_buffer #(
  parameter int N_COLS_ARRAY             = 16,
  parameter int I_WIDTH                  = 8,
  parameter int F_WIDTH                  = 8,
  parameter int ACC_WIDTH                = 24,
  parameter int NUMBER_SUPPORTED_FILTERS = 32,
  parameter int DEPTH                    = 64,
  parameter int ROUND_WIDTH              = 4,
  localparam int OUT_W = I_WIDTH + F_WIDTH,
  localparam int PW    = $clog2(DEPTH + 1),
  localparam int NFW   = $clog2(NUMBER_SUPPORTED_FILTERS + 1),
  localparam int SW    = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   general_rst_ni,
  input  logic                   start_i,
  input  logic [ROUND_WIDTH-1:0] n_round_i,
  input  logic [PW-1:0]          n_pixels_i,
  input  logic [NFW-1:0]         n_filters_i,
  input  logic                   relu_en_i,
  input  logic [SW-1:0]          shift_i,
  psum_accum_buffer_if.slave     bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o,
  output logic                   err_o
);
  localparam int NG  = (NUMBER_SUPPORTED_FILTERS + N_COLS_ARRAY - 1) / N_COLS_ARRAY;
  localparam int NFP = NG * N_COLS_ARRAY;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW  = (NFP > 1) ? $clog2(NFP) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = {{(ACC_WIDTH-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = {{(ACC_WIDTH-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic sum_ovf(input logic signed [ACC_WIDTH:0] v);
    return v[ACC_WIDTH] ^ v[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] v);
    if (sum_ovf(v)) return v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_WIDTH-1:0] a,
                                                        input logic relu, input logic [SW-1:0] sh);
    logic signed [ACC_WIDTH-1:0] v;
    v = (relu && a[ACC_WIDTH-1]) ? '0 : a;
    v = v >>> sh;
    if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic [1:0]             state;
  logic [ROUND_WIDTH-1:0] round_q;
  logic [ROUND_WIDTH-1:0] n_round_q;
  logic [PW-1:0]          n_pixels_q;
  logic [NFW-1:0]         n_filters_q;
  logic                   relu_q;
  logic [SW-1:0]          shift_q;
  logic [AW-1:0]          dp;
  logic [FW-1:0]          df;
  logic                   issued;

  logic signed [ACC_WIDTH-1:0] acc_mem [DEPTH][NFP];

  logic                        accept_beat;
  logic                        beat_err;
  logic                        sat_hit;
  logic                        wr_en  [N_COLS_ARRAY];
  logic [FW-1:0]               wr_f   [N_COLS_ARRAY];
  logic signed [ACC_WIDTH-1:0] wr_val [N_COLS_ARRAY];

  logic                    vld_p0;
  logic signed [OUT_W-1:0] data_p0;
  logic                    last_p0;
  logic signed [OUT_W-1:0] drain_word;
  logic                    last_pix;
  logic                    last_flt;
  logic                    fire;

  assign accept_beat = (state == ACCUM) && bus.in_valid_i;

  // Accumulate stage: single-cycle read-modify-write, so a back-to-back beat
  // to the same entry reads the value written at the previous edge.
  always_comb begin
    logic signed [OUT_W-1:0]   col;
    logic signed [ACC_WIDTH:0] sum;
    int                        f;
    beat_err = 1'b0;
    sat_hit  = 1'b0;
    col      = '0;
    sum      = '0;
    f        = 0;
    for (int c = 0; c < N_COLS_ARRAY; c++) begin
      wr_en[c]  = 1'b0;
      wr_f[c]   = '0;
      wr_val[c] = '0;
    end
    if (accept_beat) begin
      if (PW'(bus.in_addr_i) >= n_pixels_q) begin
        beat_err = 1'b1;
      end else begin
        for (int c = 0; c < N_COLS_ARRAY; c++) begin
          f   = int'(bus.in_group_i) * N_COLS_ARRAY + c;
          col = bus.in_data_i[c*OUT_W +: OUT_W];
          if (f < NUMBER_SUPPORTED_FILTERS) begin
            wr_en[c] = 1'b1;
            wr_f[c]  = FW'(f);
            if (round_q == '0) begin
              wr_val[c] = ACC_WIDTH'(col);
            end else begin
              sum       = (ACC_WIDTH+1)'(acc_mem[bus.in_addr_i][FW'(f)]) + (ACC_WIDTH+1)'(col);
              wr_val[c] = sat_acc(sum);
              if (sum_ovf(sum)) sat_hit = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_COLS_ARRAY; c++) begin
      if (wr_en[c]) acc_mem[bus.in_addr_i][wr_f[c]] <= wr_val[c];
    end
  end

  assign drain_word = post_proc(acc_mem[dp][df], relu_q, shift_q);
  assign last_pix   = (int'(dp) == int'(n_pixels_q) - 1);
  assign last_flt   = (int'(df) == int'(n_filters_q) - 1);
  assign fire       = vld_p0 && bus.out_ready_i;

  // Output stage p0: skid-free register, reloaded when empty or on a handshake.
  always_ff @(posedge clk_i or negedge general_rst_ni) begin
    if (!general_rst_ni) begin
      state       <= IDLE;
      round_q     <= '0;
      n_round_q   <= '0;
      n_pixels_q  <= '0;
      n_filters_q <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      dp          <= '0;
      df          <= '0;
      issued      <= 1'b0;
      vld_p0      <= 1'b0;
      data_p0     <= '0;
      last_p0     <= 1'b0;
      done_o      <= 1'b0;
      ovf_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            n_round_q   <= (n_round_i == '0) ? ROUND_WIDTH'(1) : n_round_i;
            n_pixels_q  <= n_pixels_i;
            n_filters_q <= n_filters_i;
            relu_q      <= relu_en_i;
            shift_q     <= shift_i;
            round_q     <= '0;
            ovf_o       <= 1'b0;
            err_o       <= 1'b0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat_err) err_o <= 1'b1;
          if (sat_hit) ovf_o <= 1'b1;
          if (bus.in_round_done_i) begin
            round_q <= round_q + ROUND_WIDTH'(1);
            if (round_q + ROUND_WIDTH'(1) == n_round_q) begin
              state  <= DRAIN;
              dp     <= '0;
              df     <= '0;
              issued <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (fire && last_p0) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            done_o  <= 1'b1;
            state   <= IDLE;
          end else if ((!vld_p0 || fire) && !issued) begin
            vld_p0  <= 1'b1;
            data_p0 <= drain_word;
            last_p0 <= last_pix && last_flt;
            if (last_flt) begin
              df     <= '0;
              dp     <= dp + AW'(1);
              issued <= last_pix;
            end else begin
              df <= df + FW'(1);
            end
          end else if (fire) begin
            vld_p0 <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid_o = vld_p0;
  assign bus.out_data_o  = data_p0;
  assign bus.out_last_o  = last_p0;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer: hand-computed drain words, flags and
// handshake behaviour across rounds, saturation, post-processing, errors and reset.
module tb_psum_accum_buffer;
  localparam int RW = 9;
  localparam int NC = 16;
  localparam int OW = 16;
  localparam int AW = 6;
  localparam int GW = 1;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [RW-1:0] n_round_i;
  logic [6:0]    n_pixels_i;
  logic [5:0]    n_filters_i;
  logic          relu_en_i;
  logic [4:0]    shift_i;
  logic          busy_o, done_o, ovf_o, err_o;

  psum_accum_buffer_if bus ();

  psum_accum_buffer #(.ROUND_WIDTH(RW)) dut (
    .clk_i          (clk_i),
    .general_rst_ni (rst_n),
    .start_i        (start_i),
    .n_round_i      (n_round_i),
    .n_pixels_i     (n_pixels_i),
    .n_filters_i    (n_filters_i),
    .relu_en_i      (relu_en_i),
    .shift_i        (shift_i),
    .bus            (bus.slave),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ovf_o          (ovf_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;
  logic signed [OW-1:0] got_d[$];
  logic                 got_l[$];
  int                   done_cyc;
  int                   last_cyc;
  logic                 rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NC*OW-1:0] ramp(input int base, input int step);
    logic [NC*OW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*OW +: OW] = OW'(base + step * c);
    return v;
  endfunction

  function automatic logic [NC*OW-1:0] col0(input int val);
    logic [NC*OW-1:0] v;
    v = '0;
    v[OW-1:0] = OW'(val);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic go(input int nr, input int np, input int nf, input logic relu, input int sh);
    start_i     = 1'b1;
    n_round_i   = RW'(nr);
    n_pixels_i  = 7'(np);
    n_filters_i = 6'(nf);
    relu_en_i   = relu;
    shift_i     = 5'(sh);
    tick();
    start_i = 1'b0;
  endtask

  task automatic beat(input int addr, input int grp, input logic [NC*OW-1:0] data, input logic rd);
    bus.in_valid_i      = 1'b1;
    bus.in_addr_i       = AW'(addr);
    bus.in_group_i      = GW'(grp);
    bus.in_data_i       = data;
    bus.in_round_done_i = rd;
    tick();
    bus.in_valid_i      = 1'b0;
    bus.in_round_done_i = 1'b0;
  endtask

  task automatic rdone();
    bus.in_round_done_i = 1'b1;
    tick();
    bus.in_round_done_i = 1'b0;
  endtask

  // Collects accepted words until done_o is seen or the cycle budget runs out.
  task automatic drain(input logic bp, input int max_cyc);
    int k;
    logic stall_prev;
    logic signed [OW-1:0] d_prev;
    got_d.delete();
    got_l.delete();
    done_cyc   = -1;
    last_cyc   = -1;
    stall_prev = 1'b0;
    d_prev     = '0;
    k          = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (stall_prev) chk("hold_data", bus.out_data_o, d_prev);
      bus.out_ready_i = bp ? rdy_pat[k % 4] : 1'b1;
      k++;
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_d.push_back(bus.out_data_o);
        got_l.push_back(bus.out_last_o);
        if (bus.out_last_o) last_cyc = cyc;
      end
      stall_prev = bus.out_valid_o && !bus.out_ready_i;
      d_prev     = bus.out_data_o;
      tick();
    end
    chk("done_latency", done_cyc - last_cyc, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    start_i = 1'b0; n_round_i = '0; n_pixels_i = '0; n_filters_i = '0;
    relu_en_i = 1'b0; shift_i = '0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_addr_i = '0;
    bus.in_group_i = '0; bus.in_round_done_i = 1'b0; bus.out_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", bus.out_data_o, 0);
    rst_n = 1'b1;
    tick();

    // Single round, one pixel, 16 filters: ramp -8..7
    go(1, 1, 16, 1'b0, 0);
    chk("t1_busy", busy_o, 1);
    beat(0, 0, ramp(-8, 1), 1'b1);
    drain(1'b0, 100);
    chk("t1_count", got_d.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_word", got_d[i], i - 8);
      chk("t1_last", got_l[i], (i == 15) ? 1 : 0);
    end
    chk("t1_idle", busy_o, 0);
    chk("t1_valid_low", bus.out_valid_o, 0);

    // Three rounds into pixel 2, group 1; repeated to show round 0 overwrites
    for (int run = 0; run < 2; run++) begin
      go(3, 3, 32, 1'b0, 0);
      beat(2, 1, ramp(100, 0), 1'b0);
      rdone();
      beat(2, 1, ramp(200, 0), 1'b1);
      beat(2, 1, ramp(-50, 0), 1'b1);
      drain(1'b0, 200);
      chk("t2_count", got_d.size(), 96);
      for (int i = 0; i < 16; i++) chk("t2_word", got_d[80 + i], 250);
      chk("t2_last", got_l[95], 1);
    end

    // Saturation: 300 rounds of 32767 into column 0
    go(300, 1, 1, 1'b0, 0);
    for (int r = 0; r < 300; r++) beat(0, 0, col0(32767), 1'b1);
    chk("t3_ovf", ovf_o, 1);
    drain(1'b0, 20);
    chk("t3_count", got_d.size(), 1);
    chk("t3_word", got_d[0], 32767);

    // ReLU and shift
    go(1, 1, 1, 1'b1, 0);
    chk("t4_ovf_clr", ovf_o, 0);
    beat(0, 0, col0(-40), 1'b1);
    drain(1'b0, 20);
    chk("t4_relu", got_d[0], 0);
    go(1, 1, 1, 1'b0, 3);
    beat(0, 0, col0(1000), 1'b1);
    drain(1'b0, 20);
    chk("t4_shift_pos", got_d[0], 125);
    go(1, 1, 1, 1'b0, 3);
    beat(0, 0, col0(-1000), 1'b1);
    drain(1'b0, 20);
    chk("t4_shift_neg", got_d[0], -125);

    // Backpressure, back-to-back same-address beats, same-cycle beat+done on the last round
    go(2, 2, 3, 1'b0, 0);
    beat(0, 0, ramp(10, 1), 1'b0);
    beat(1, 0, ramp(50, 1), 1'b0);
    rdone();
    beat(0, 0, ramp(1, 1), 1'b0);
    beat(0, 0, ramp(1, 1), 1'b0);
    beat(1, 0, ramp(2, 1), 1'b1);
    drain(1'b1, 100);
    chk("t5_count", got_d.size(), 6);
    for (int i = 0; i < 3; i++) chk("t5_p0", got_d[i], 12 + 3 * i);
    for (int i = 0; i < 3; i++) chk("t5_p1", got_d[3 + i], 52 + 2 * i);
    chk("t5_last", got_l[5], 1);
    chk("t5_not_last", got_l[4], 0);

    // Out-of-range address drops the beat and sets err_o
    go(1, 4, 2, 1'b0, 0);
    beat(5, 0, ramp(77, 0), 1'b0);
    chk("t6_err", err_o, 1);
    beat(1, 0, ramp(9, 0), 1'b1);
    drain(1'b0, 40);
    chk("t6_count", got_d.size(), 8);
    chk("t6_p1f0", got_d[2], 9);
    chk("t6_p1f1", got_d[3], 9);

    // Reset while stalled in DRAIN, then a fresh run
    go(1, 4, 32, 1'b0, 0);
    chk("t7_err_clr", err_o, 0);
    beat(7, 0, ramp(5, 0), 1'b0);
    beat(0, 0, ramp(3, 1), 1'b1);
    bus.out_ready_i = 1'b0;
    tick(); tick(); tick();
    chk("t7_pre_valid", bus.out_valid_o, 1);
    chk("t7_pre_data", bus.out_data_o, 3);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", bus.out_valid_o, 0);
    chk("t7_rst_data", bus.out_data_o, 0);
    chk("t7_rst_last", bus.out_last_o, 0);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_done", done_o, 0);
    chk("t7_rst_err", err_o, 0);
    chk("t7_rst_ovf", ovf_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_idle_done", done_o, 0);
    go(1, 1, 2, 1'b0, 0);
    chk("t7_busy", busy_o, 1);
    beat(0, 0, ramp(20, 5), 1'b1);
    drain(1'b0, 20);
    chk("t7_count", got_d.size(), 2);
    chk("t7_w0", got_d[0], 20);
    chk("t7_w1", got_d[1], 25);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_accum_buffer.md
Name: psum_accum_buffer

Overview:
- Parametrised successor to the per-filter output store and final output select.
- Accumulates the N_COLS_ARRAY column partial sums from the systolic array across multiple channel rounds into a per-pixel, per-filter accumulator buffer.
- After the programmed number of rounds, applies optional ReLU, arithmetic shift and saturation, then drains the results as a valid/ready stream.
- Sits between the systolic array result bus and the downstream store or host port.

Parameters:
- N_COLS_ARRAY, 16, columns per input beat (one filter per column).
- I_WIDTH, 8, feature width.
- F_WIDTH, 8, weight width. Input column and output word width is OUT_W = I_WIDTH+F_WIDTH.
- ACC_WIDTH, 24, signed accumulator width (must be >= OUT_W).
- NUMBER_SUPPORTED_FILTERS, 32, total filter slots. Filter groups NG = ceil(NUMBER_SUPPORTED_FILTERS/N_COLS_ARRAY).
- DEPTH, 64, output pixels per filter.
- ROUND_WIDTH, 4, width of the round count.

Ports:
- clk_i  in  1  clock, rising edge.
- general_rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  start pulse; sampled in IDLE only.
- n_round_i  in  ROUND_WIDTH  rounds to accumulate; 0 is treated as 1. Latched on start.
- n_pixels_i  in  clog2(DEPTH+1)  pixels to drain (1..DEPTH). Latched on start.
- n_filters_i  in  clog2(NUMBER_SUPPORTED_FILTERS+1)  filters to drain (1..NUMBER_SUPPORTED_FILTERS). Latched on start.
- relu_en_i  in  1  ReLU enable. Latched on start.
- shift_i  in  clog2(ACC_WIDTH)  arithmetic right shift applied on drain. Latched on start.
- in_valid_i  in  1  input beat valid.
- in_data_i  in  N_COLS_ARRAY*OUT_W  packed signed column results; column c occupies [(c+1)*OUT_W-1 : c*OUT_W].
- in_addr_i  in  clog2(DEPTH)  pixel index of the beat.
- in_group_i  in  clog2(NG)  filter group; column c maps to filter in_group_i*N_COLS_ARRAY + c.
- in_round_done_i  in  1  pulse: current round complete.
- out_valid_o  out  1  drain word valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  OUT_W  signed drained result.
- out_last_o  out  1  asserted on the final drain word.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse after the last drain handshake.
- ovf_o  out  1  sticky: accumulator saturated. Cleared on accepted start.
- err_o  out  1  sticky: beat dropped because of an out-of-range address. Cleared on accepted start.

Behaviour:
- Reset (async, low):
  - state = IDLE; round counter and drain counters = 0.
  - All outputs 0.
  - Accumulator contents are not cleared; round 0 overwrites them.
  - Reset mid-operation aborts without emitting done_o.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - start_i=1: latch configuration, clear ovf_o/err_o and the round counter, go to ACCUM next cycle.
  - in_valid_i and in_round_done_i are ignored.
- ACCUM, on each in_valid_i=1 beat, for every column c:
  - Compute f = in_group_i*N_COLS_ARRAY + c.
  - If f >= NUMBER_SUPPORTED_FILTERS, skip that column silently.
  - If round==0: acc[in_addr_i][f] = sign-extend(col).
  - Otherwise: acc += sign-extend(col), saturating to the signed ACC_WIDTH range. Any saturation sets ovf_o.
  - The write lands at the clock edge.
  - Back-to-back beats to the same address/group must accumulate correctly (read-modify-write with forwarding, no stall).
  - in_addr_i >= n_pixels: the whole beat is dropped and err_o is set.
- Round completion:
  - in_round_done_i in ACCUM: round += 1.
  - If round+1 == max(n_round,1), go to DRAIN.
  - in_valid_i and in_round_done_i in the same cycle: the beat belongs to the current round (uses the pre-increment round value), then the counter advances.
  - in_valid_i during DRAIN is ignored; no input backpressure exists.
- DRAIN:
  - Order is pixel-major: for p in 0..n_pixels-1, for f in 0..n_filters-1.
  - out_valid_o rises 1 cycle after entering DRAIN.
  - The output register loads the next word when out_valid_o=0 or (out_valid_o & out_ready_i).
  - Without a handshake, out_data_o and out_last_o hold stable.
  - Full throughput: 1 word/cycle when out_ready_i is held high.
- Post-processing per word:
  - v = acc; if relu_en and v<0, v=0.
  - v = v >>> shift.
  - Saturate v to the signed OUT_W range.
- Drain completion:
  - out_last_o = 1 on word (n_pixels-1, n_filters-1).
  - After its handshake: out_valid_o=0, done_o=1 for one cycle, state = IDLE.
- start_i while busy_o=1 is ignored.

Test Plan:
- Single round, 1 pixel, n_filters=16:
  - Stimulus: group0 beat with column c = c-8, relu off, shift 0, out_ready=1.
  - Required: 16 words -8..7 in order; out_last_o on the 16th; done_o pulses the next cycle.
- Three rounds, pixel 2, group1:
  - Stimulus: column values 100, then 200, then -50 per round; n_filters=32, n_pixels=3.
  - Required: words at filter indices 16..31 for pixel 2 read 250; round 0 overwrote stale data.
- Saturation, ACC_WIDTH=24:
  - Stimulus: 300 rounds' worth of 32767 into one column (n_round is enough via ROUND_WIDTH override).
  - Required: output 32767, ovf_o=1.
- ReLU and shift:
  - Stimulus: acc=-40 with relu on gives 0.
  - Stimulus: acc=1000 with shift=3 gives 125.
  - Stimulus: acc=-1000 with relu off and shift=3 gives -125.
- Backpressure:
  - Stimulus: toggle out_ready_i 1,0,0,1.
  - Required: data held stable while stalled; no word lost or duplicated; same-cycle in_valid_i and in_round_done_i on the last round lands in the sum.
- Errors and reset:
  - Stimulus: in_addr_i=5 with n_pixels=4.
  - Required: beat dropped, err_o=1.
  - Stimulus: general_rst_ni low mid-DRAIN.
  - Required: all outputs 0, state IDLE; a new start_i works correctly.
